// File: rtl/uart_pkg.sv
// Shared definitions for the output UART transmitter: state enumeration, bit-period helper, frame lengths.
// The PARITY state and the 11-bit frame exist only when UART_TX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;
    localparam int FRAME_BITS = 11;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } tx_state_e;
    localparam int FRAME_BITS = 10;
`endif

    localparam int DATA_BITS = 8;

    // Integer truncation: any remainder of CLK_HZ/BAUD is absorbed as baud error.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with show-ahead read data; full/empty come from an occupancy counter.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];
    assign level   = count;

    // Storage needs no reset; only pointers and occupancy define content.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/output_uart_tx.sv
// Byte-buffered UART transmitter (8N1, or 8E1 when UART_TX_PARITY_EN is defined).
// Bytes strobed in on output_valid are queued and sent back-to-back, LSB first.
module output_uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          output_valid,
    input  logic [7:0]                    output_data,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic                          tx_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CPB - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ovf_q;
    logic             bit_done;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (output_valid),
        .pop   (fifo_pop),
        .din   (output_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign bit_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Popping on the last stop cycle keeps frames contiguous.
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level is decoded from the next state so uart_tx can be a plain register.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            if (state_q == ST_IDLE || bit_done) begin
                baud_q <= '0;
            end else begin
                baud_q <= baud_q + CNT_W'(1);
            end
            if (state_q != ST_DATA) begin
                bit_q <= '0;
            end else if (bit_done) begin
                bit_q <= bit_q + 3'd1;
            end
            if (output_valid && fifo_full && !fifo_pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (fifo_pop) begin
            parity_q <= ^fifo_dout;
        end
    end
`endif

    assign uart_tx     = tx_q;
    assign tx_overflow = ovf_q;
    assign tx_busy     = !((state_q == ST_IDLE) && (fifo_level == '0));

endmodule

// File: tb/tb_output_uart_tx.sv
// Bench for output_uart_tx: queue-based line model compared every cycle, line decoder with expected queue.
`timescale 1ns/1ps
module tb_output_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FC = CPB * NBITS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       output_valid = 1'b0;
    logic [7:0] output_data = 8'h00;
    logic       uart_tx;
    logic       tx_busy;
    logic       tx_overflow;
    logic [4:0] fifo_level;

    output_uart_tx #(
        .CLK_HZ     (16),
        .BAUD       (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .output_valid (output_valid),
        .output_data  (output_data),
        .uart_tx      (uart_tx),
        .tx_busy      (tx_busy),
        .tx_overflow  (tx_overflow),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a byte queue plus the position inside the frame on the line.
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    int         m_pos = -1;
    logic [7:0] m_cur = 8'h00;
    logic       m_ovf = 1'b0;

    function automatic logic model_line(input int pos, input logic [7:0] cur);
        int b;
        if (pos < 0) return 1'b1;
        b = pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
        if (b == 9 && NBITS == 11) return ^cur;
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                exp_q.delete();
                m_pos = -1;
                m_ovf = 1'b0;
            end else begin
                if (m_q.size() > 0 && (m_pos < 0 || m_pos == FC - 1)) begin
                    m_cur = m_q.pop_front();
                    m_pos = 0;
                end else if (m_pos >= 0) begin
                    m_pos++;
                    if (m_pos == FC) m_pos = -1;
                end
                if (output_valid) begin
                    if (m_q.size() < DEPTH) begin
                        m_q.push_back(output_data);
                        exp_q.push_back(output_data);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    // Compare process and line decoder, both sampling on the falling edge.
    logic       rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    int         rx_count = 0;
    logic [7:0] last_rx = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_active = 1'b0;
            end else begin
                check("line", uart_tx, model_line(m_pos, m_cur));
                check("busy", tx_busy, (m_pos >= 0 || m_q.size() > 0));
                check("overflow", tx_overflow, m_ovf);
                check("level", fifo_level, m_q.size());
                if (!rx_active) begin
                    if (uart_tx === 1'b0) begin
                        rx_active = 1'b1;
                        rx_cnt = 0;
                    end
                end else begin
                    rx_cnt++;
                    if (rx_cnt % CPB == CPB / 2) begin
                        int b;
                        b = rx_cnt / CPB;
                        if (b >= 1 && b <= 8) rx_byte[b-1] = uart_tx;
`ifdef UART_TX_PARITY_EN
                        if (b == 9) check("rx_parity", uart_tx, ^rx_byte);
`endif
                        if (b == NBITS - 1) begin
                            check("rx_stop", uart_tx, 1'b1);
                            if (exp_q.size() == 0) begin
                                check("rx_unexpected", rx_byte, 32'hFFFF_FFFF);
                            end else begin
                                check("rx_byte", rx_byte, exp_q.pop_front());
                            end
                            rx_count++;
                            last_rx = rx_byte;
                            rx_active = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic push(input logic [7:0] d);
        output_valid = 1'b1;
        output_data  = d;
        @(negedge clk);
        output_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((m_pos >= 0 || m_q.size() > 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, (m_pos < 0 && m_q.size() == 0), 1'b1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [7:0] pat;
        int         rx_before;
        int         n;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_line", uart_tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_overflow", tx_overflow, 1'b0);
        check("rst_level", fifo_level, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0x55 pushed in cycle 0
        pat = 8'h55;
        output_valid = 1'b1;
        output_data  = pat;
        for (int c = 1; c <= FC + 10; c++) begin
            @(negedge clk);
            output_valid = 1'b0;
            if (c == 1) check("t1_idle_c1", uart_tx, 1'b1);
            if (c == 2) check("t1_start_c2", uart_tx, 1'b0);
            if (c == 17) check("t1_start_c17", uart_tx, 1'b0);
            if (c >= 18 && c < 146 && (c - 18) % CPB == 8) check("t1_data", uart_tx, pat[(c-18)/CPB]);
            if (c == 2 + (NBITS - 1) * CPB) check("t1_stop", uart_tx, 1'b1);
            if (c == 1 + FC) check("t1_busy_last", tx_busy, 1'b1);
            if (c == 2 + FC) begin
                check("t1_busy_fall", tx_busy, 1'b0);
                check("t1_rx", last_rx, 8'h55);
            end
        end

        // 18 consecutive pushes: the 18th is dropped
        rx_before = rx_count;
        for (int i = 0; i < 18; i++) push(8'(i));
        check("t2_overflow", tx_overflow, 1'b1);
        check("t2_level", fifo_level, 16);
        drain("t2_drain");
        check("t2_rx_count", rx_count - rx_before, 17);
        check("t2_last", last_rx, 8'h10);

`ifdef UART_TX_PARITY_EN
        // Parity bit values for 0x07 and 0x03
        push(8'h07);
        repeat (2 + 9 * CPB + 8 - 1) @(negedge clk);
        check("t3_parity_07", uart_tx, 1'b1);
        drain("t3_drain_07");
        push(8'h03);
        repeat (2 + 9 * CPB + 8 - 1) @(negedge clk);
        check("t3_parity_03", uart_tx, 1'b0);
        drain("t3_drain_03");
`endif

        // Reset during data bit 3 of 0xA5 with 0x3C queued
        do_reset();
        push(8'hA5);
        push(8'h3C);
        repeat (68) @(negedge clk);
        check("t4_pre_line", uart_tx, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_line", uart_tx, 1'b1);
        check("t4_rst_level", fifo_level, 0);
        check("t4_rst_busy", tx_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        rx_before = rx_count;
        repeat (3 * FC) @(negedge clk);
        check("t4_no_tx", rx_count - rx_before, 0);
        check("t4_overflow", tx_overflow, 1'b0);

        // Push and pop together while full
        rx_before = rx_count;
        for (int i = 0; i < 17; i++) push(8'h80 + 8'(i));
        check("t5_full", fifo_level, 16);
        n = 0;
        while (m_pos != FC - 1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("t5_wait_pop", (n < 1000), 1'b1);
        push(8'hEE);
        check("t5_level", fifo_level, 16);
        check("t5_overflow", tx_overflow, 1'b0);
        drain("t5_drain");
        check("t5_rx_count", rx_count - rx_before, 18);
        check("t5_last", last_rx, 8'hEE);

        // Random bytes with random gaps, including bursts that may overflow
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 2 * FC);
            repeat (gap) @(negedge clk);
            push(8'($urandom_range(0, 255)));
        end
        drain("t6_drain");
        check("t6_exp_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
